// File: rtl/data_ram_responder_pkg.sv
// Shared encodings for the data-memory responder: FSM states, access op and
// the default access latency.
package data_ram_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int DEFAULT_LATENCY = 3;

    // Wide enough for LATENCY-2 across the legal latency range 1..15.
    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/data_ram_array.sv
// Synchronous single-port word RAM with a registered read port; only the read
// register is reset, the storage array itself keeps its contents.
module data_ram_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    // Read data only moves on an explicit read, so it holds across writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// Memory-side responder for the core's data port: accepts a request, stalls the
// core for LATENCY cycles, then completes the read or write in a single DONE cycle.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ram_cs,
    input  logic             mem_ren,
    input  logic             mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_dout,
    output logic [31:0]      mem_din,
    output logic             ram_stall,
    output logic             busy,
    output logic [CNT_W-1:0] access_cnt
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
        (LATENCY >= 2) ? LAT_CNT_W'(LATENCY - 2) : '0;

    state_t                state;
    state_t                state_nxt;
    logic [LAT_CNT_W-1:0]  lat_cnt;
    logic [LAT_CNT_W-1:0]  lat_cnt_nxt;
    op_t                   op_q;
    logic [ADDR_W-1:0]     idx_q;
    logic [31:0]           wdata_q;
    logic                  req;
    logic                  accept;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_W-1:0]     addr_idx;
    logic [ADDR_W-1:0]     ram_index;
    logic                  unused_addr_bits;

    assign req              = ram_cs & (mem_ren | mem_wen);
    assign addr_idx         = mem_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_READ;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            op_q    <= mem_wen ? OP_WRITE : OP_READ;
            idx_q   <= addr_idx;
            wdata_q <= mem_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            access_cnt <= '0;
        end else if (state == ST_DONE) begin
            access_cnt <= access_cnt + CNT_W'(1);
        end
    end

    // The RAM read is launched on the edge that enters DONE so mem_din is
    // valid for the whole DONE cycle; a read entering DONE straight from IDLE
    // must use the live address because nothing has been latched yet.
    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        accept      = 1'b0;
        ram_re      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = ST_DONE;
                        ram_re    = ~mem_wen;
                    end else begin
                        state_nxt   = ST_BUSY;
                        lat_cnt_nxt = LAT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (!ram_cs) begin
                    state_nxt = ST_IDLE;
                end else if (lat_cnt == '0) begin
                    state_nxt = ST_DONE;
                    ram_re    = (op_q == OP_READ);
                end else begin
                    lat_cnt_nxt = lat_cnt - LAT_CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ram_we    = (state == ST_DONE) && (op_q == OP_WRITE);
    assign ram_index = (state == ST_IDLE) ? addr_idx : idx_q;
    assign busy      = (state != ST_IDLE);

    // Gated by rst so the core is released the moment reset is asserted.
    assign ram_stall = ~rst & (((state == ST_IDLE) & req) | ((state == ST_BUSY) & ram_cs));

    data_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .index (ram_index),
        .wdata (wdata_q),
        .rdata (mem_din)
    );

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: a LATENCY=3 and a LATENCY=1 instance share the
// same core-side inputs and are each checked every cycle against a transaction model.
module tb_data_ram_responder;

    localparam int TB_ADDR_W = 10;
    localparam int DEPTH     = 2 ** TB_ADDR_W;

    logic        clk;
    logic        rst;
    logic        ram_cs;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] din_w   [2];
    logic        stall_w [2];
    logic        busy_w  [2];
    logic [15:0] cnt_w   [2];

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int lat [2] = '{3, 1};

    // Transaction model: one outstanding access per instance, tracked by its
    // age in cycles since the accept cycle.
    logic [31:0] m_mem       [2][DEPTH];
    bit          m_known     [2][DEPTH];
    bit          m_pend      [2];
    int          m_age       [2];
    bit          m_wr        [2];
    int          m_idx       [2];
    logic [31:0] m_data      [2];
    logic [31:0] m_din       [2];
    bit          m_din_known [2];
    int          m_cnt       [2];

    data_ram_responder #(.ADDR_W(TB_ADDR_W), .LATENCY(3), .CNT_W(16)) dut_lat3 (
        .clk        (clk),
        .rst        (rst),
        .ram_cs     (ram_cs),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_din    (din_w[0]),
        .ram_stall  (stall_w[0]),
        .busy       (busy_w[0]),
        .access_cnt (cnt_w[0])
    );

    data_ram_responder #(.ADDR_W(TB_ADDR_W), .LATENCY(1), .CNT_W(16)) dut_lat1 (
        .clk        (clk),
        .rst        (rst),
        .ram_cs     (ram_cs),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_din    (din_w[1]),
        .ram_stall  (stall_w[1]),
        .busy       (busy_w[1]),
        .access_cnt (cnt_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]      = 1'b0;
            m_age[k]       = 0;
            m_din[k]       = 32'h0;
            m_din_known[k] = 1'b1;
            m_cnt[k]       = 0;
        end
    endtask

    task automatic model_step(input int k);
        bit req;
        int idx;
        req = ram_cs & (mem_ren | mem_wen);
        idx = int'(mem_addr[TB_ADDR_W+1:2]);
        if (!m_pend[k]) begin
            if (req) begin
                m_pend[k] = 1'b1;
                m_age[k]  = 1;
                m_wr[k]   = mem_wen;
                m_idx[k]  = idx;
                m_data[k] = mem_dout;
            end
        end else if (m_age[k] < lat[k]) begin
            if (!ram_cs) m_pend[k] = 1'b0;
            else         m_age[k]++;
        end else begin
            if (m_wr[k]) begin
                m_mem[k][m_idx[k]]   = m_data[k];
                m_known[k][m_idx[k]] = 1'b1;
            end
            m_cnt[k]  = (m_cnt[k] + 1) % 65536;
            m_pend[k] = 1'b0;
        end
        if (m_pend[k] && m_age[k] == lat[k] && !m_wr[k]) begin
            m_din[k]       = m_mem[k][m_idx[k]];
            m_din_known[k] = m_known[k][m_idx[k]];
        end
    endtask

    // Per-cycle compare against the model, then advance the model past the edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                bit req;
                bit exp_stall;
                req       = ram_cs & (mem_ren | mem_wen);
                exp_stall = !m_pend[k] ? req : ((m_age[k] < lat[k]) ? ram_cs : 1'b0);
                check_output($sformatf("lat%0d stall", lat[k]), {31'b0, stall_w[k]}, {31'b0, exp_stall});
                check_output($sformatf("lat%0d busy", lat[k]), {31'b0, busy_w[k]}, {31'b0, m_pend[k]});
                check_output($sformatf("lat%0d cnt", lat[k]), {16'b0, cnt_w[k]}, 32'(m_cnt[k]));
                if (m_din_known[k])
                    check_output($sformatf("lat%0d din", lat[k]), din_w[k], m_din[k]);
                model_step(k);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ram_cs  = 1'b0;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
    endtask

    // Behaves like the core: holds the request until instance k drops ram_stall.
    task automatic apply_stimulus(input int k, input logic wen, input logic ren,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  output int stalls, output logic [31:0] din_done,
                                  output int done_cycle);
        ram_cs   = 1'b1;
        mem_wen  = wen;
        mem_ren  = ren;
        mem_addr = addr;
        mem_dout = data;
        stalls   = 0;
        forever begin
            @(negedge clk);
            if (!stall_w[k]) break;
            stalls++;
            if (stalls > 40) begin
                total++;
                bad++;
                $display("[TB] FAIL access timeout: stall still %0d after %0d cycles, required 0", stall_w[k], stalls);
                break;
            end
            @(posedge clk);
            #1;
        end
        din_done   = din_w[k];
        done_cycle = cycle;
        next_cycle();
    endtask

    initial begin
        int          stalls;
        int          dc;
        int          dc_prev;
        logic [31:0] rd;
        logic [15:0] cnt_snap;
        logic [31:0] r;

        rst      = 1'b1;
        ram_cs   = 1'b0;
        mem_ren  = 1'b0;
        mem_wen  = 1'b0;
        mem_addr = 32'h0;
        mem_dout = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) next_cycle();
        for (int k = 0; k < 2; k++) begin
            check_output("reset stall", {31'b0, stall_w[k]}, 32'h0);
            check_output("reset busy", {31'b0, busy_w[k]}, 32'h0);
            check_output("reset din", din_w[k], 32'h0);
            check_output("reset cnt", {16'b0, cnt_w[k]}, 32'h0);
        end

        $display("[TB] write then read");
        apply_stimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, stalls, rd, dc);
        check_output("write stall cycles", 32'(stalls), 32'd3);
        check_output("cnt after write", {16'b0, cnt_w[0]}, 32'd1);
        set_idle();
        next_cycle();
        apply_stimulus(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, stalls, rd, dc);
        check_output("read stall cycles", 32'(stalls), 32'd3);
        check_output("read data", rd, 32'hDEAD_BEEF);
        check_output("cnt after read", {16'b0, cnt_w[0]}, 32'd2);
        set_idle();
        next_cycle();

        $display("[TB] address wrap and write priority");
        apply_stimulus(0, 1'b1, 1'b0, 32'h0000_1010, 32'h0000_1234, stalls, rd, dc);
        set_idle();
        next_cycle();
        apply_stimulus(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, stalls, rd, dc);
        check_output("wrapped read", rd, 32'h0000_1234);
        apply_stimulus(0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0055, stalls, rd, dc);
        check_output("din held over write", rd, 32'h0000_1234);
        set_idle();
        next_cycle();
        apply_stimulus(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, stalls, rd, dc);
        check_output("priority read", rd, 32'h0000_0055);
        set_idle();
        next_cycle();

        $display("[TB] abort");
        apply_stimulus(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_1111, stalls, rd, dc);
        set_idle();
        next_cycle();
        ram_cs   = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = 32'h0000_0020;
        mem_dout = 32'h0000_AAAA;
        cnt_snap = cnt_w[0];
        next_cycle();
        ram_cs = 1'b0;
        @(negedge clk);
        check_output("abort stall", {31'b0, stall_w[0]}, 32'h0);
        next_cycle();
        check_output("abort busy", {31'b0, busy_w[0]}, 32'h0);
        check_output("abort cnt", {16'b0, cnt_w[0]}, {16'b0, cnt_snap});
        set_idle();
        apply_stimulus(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0, stalls, rd, dc);
        check_output("abort old value", rd, 32'h0000_1111);
        set_idle();
        next_cycle();

        $display("[TB] back-to-back at latency 1");
        cnt_snap = cnt_w[1];
        apply_stimulus(1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, stalls, rd, dc_prev);
        check_output("b2b stall 0", 32'(stalls), 32'd1);
        check_output("b2b data 0", rd, 32'h0000_1234);
        apply_stimulus(1, 1'b0, 1'b1, 32'h0000_0040, 32'h0, stalls, rd, dc);
        check_output("b2b stall 1", 32'(stalls), 32'd1);
        check_output("b2b data 1", rd, 32'h0000_0055);
        check_output("b2b gap 1", 32'(dc - dc_prev), 32'd2);
        dc_prev = dc;
        apply_stimulus(1, 1'b0, 1'b1, 32'h0000_1010, 32'h0, stalls, rd, dc);
        check_output("b2b stall 2", 32'(stalls), 32'd1);
        check_output("b2b data 2", rd, 32'h0000_1234);
        check_output("b2b gap 2", 32'(dc - dc_prev), 32'd2);
        check_output("b2b cnt", {16'b0, 16'(cnt_w[1] - cnt_snap)}, 32'd3);
        set_idle();
        next_cycle();

        $display("[TB] reset mid-write");
        apply_stimulus(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0000_3333, stalls, rd, dc);
        set_idle();
        next_cycle();
        ram_cs   = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = 32'h0000_0030;
        mem_dout = 32'h0000_0077;
        next_cycle();
        #2;
        rst = 1'b1;
        set_idle();
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            check_output("rst stall", {31'b0, stall_w[k]}, 32'h0);
            check_output("rst busy", {31'b0, busy_w[k]}, 32'h0);
            check_output("rst din", din_w[k], 32'h0);
            check_output("rst cnt", {16'b0, cnt_w[k]}, 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        next_cycle();
        apply_stimulus(0, 1'b0, 1'b1, 32'h0000_0030, 32'h0, stalls, rd, dc);
        check_output("no write after rst", rd, 32'h0000_3333);
        set_idle();
        next_cycle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            r        = $urandom;
            ram_cs   = ($urandom_range(0, 7) != 0);
            mem_ren  = r[0];
            mem_wen  = r[1];
            mem_addr = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            mem_dout = $urandom;
            next_cycle();
        end
        set_idle();
        repeat (6) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Memory-side responder for the core's data-memory interface.
- Accepts read/write requests qualified by ram_cs and completes each after a fixed, parameterised latency.
- Holds the core with ram_stall until the access completes.
- Contains the word-addressed data RAM array; sits between the core's data port and the board-level memory map.

Parameters:
- ADDR_W, 10, word-index width; array depth = 2**ADDR_W words.
- LATENCY, 3, stall cycles per access (legal range 1..15).
- CNT_W, 16, width of the completed-access counter.

Ports:
- clk  in  1  main clock.
- rst  in  1  reset, asynchronous, active-high.
- ram_cs  in  1  chip select from core; qualifies a request.
- mem_ren  in  1  read request.
- mem_wen  in  1  write request; has priority over mem_ren if both are set.
- mem_addr  in  32  byte address; word index = mem_addr[ADDR_W+1:2]; bits [1:0] and upper bits ignored (address wraps modulo depth).
- mem_dout  in  32  write data from core.
- mem_din  out  32  read data to core.
- ram_stall  out  1  hold request to core.
- busy  out  1  high in any state other than IDLE.
- access_cnt  out  CNT_W  number of completed accesses; wraps.

Behaviour:
- Clocking and reset: clk only. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - mem_din = 0, ram_stall = 0, busy = 0, access_cnt = 0.
  - Latency counter = 0.
  - The RAM array is not reset.
- Request definition: req = ram_cs & (mem_ren | mem_wen). Op is latched on accept as WRITE if mem_wen, else READ. Address and write data are latched on accept.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if req, accept. Next state is DONE if LATENCY==1, else BUSY with counter loaded to LATENCY-2. If no req, stay in IDLE.
  - BUSY: counter decrements each cycle. At counter==0, go to DONE. If ram_cs falls, abort: go to IDLE, no write, access_cnt unchanged.
  - DONE: single cycle.
    - READ: mem_din registered with array[latched index] on entry to DONE, so it is valid throughout DONE.
    - WRITE: array[latched index] <= latched data at the DONE clock edge.
    - access_cnt increments at that same edge. Next state is IDLE.
- ram_stall is combinational: (state==IDLE & req) | (state==BUSY & ram_cs). It is 0 in DONE so the core advances at that edge.
- Timing: exactly LATENCY stall cycles per access, with completion in cycle LATENCY counting from the accept cycle 0.
- Back-to-back: a request presented in the cycle after DONE is accepted in IDLE with no extra bubble.
- Hold value: mem_din holds its last read value until the next READ completes. Writes do not change mem_din.
- Input changes during BUSY: mem_addr, mem_dout and mem_ren/mem_wen changes are ignored because latched values are used. Only ram_cs is monitored (abort).
- Read-after-write: a READ of an address written by the previous access returns the new data. The write commits before the next accept.
- Reset mid-access: return to IDLE immediately. A pending write is discarded and ram_stall drops asynchronously.
- access_cnt wraps from 2**CNT_W-1 to 0.

Decomposition:
- Shared package/define header:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - Op encoding (READ=1'b0, WRITE=1'b1).
  - Default LATENCY constant.
- One natural sub-module: data_ram_array. A synchronous single-port word RAM with we, index, wdata and registered rdata, instantiated by the FSM/control top.

Test Plan:
- Reset then idle, LATENCY=3: rst pulse mid-cycle -> ram_stall=0, busy=0, mem_din=0, access_cnt=0 immediately. Idle cycles leave all outputs at 0.
- Write then read, LATENCY=3:
  - Write 0xDEADBEEF to 0x0000_0010 -> ram_stall high for 3 cycles, low in cycle 3, access_cnt=1.
  - Then read 0x10 -> mem_din=0xDEADBEEF in its DONE cycle, access_cnt=2.
- Address wrap and priority, ADDR_W=10:
  - Write 0x1234 to 0x0000_1010 (index 4) -> read of 0x10 returns 0x1234.
  - Request with ren=wen=1 and data 0x55 -> treated as write; later read returns 0x55.
- Abort: accept a write 0xAAAA to 0x20, drop ram_cs in the first BUSY cycle -> FSM back to IDLE, ram_stall=0, access_cnt unchanged, later read of 0x20 returns the old value.
- Back-to-back, LATENCY=1: three consecutive reads held by the core -> each stalls exactly 1 cycle, completes every 2nd cycle with no extra gap, access_cnt +3.
- Reset mid-write: rst asserted in BUSY of a write 0x77 to 0x30 -> no write committed (read of 0x30 returns its prior value), ram_stall drops asynchronously with rst.
